mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_pkg.sv | 34 +++
 rtl/mult_arbiter_rr_grant.sv | 44 ++++
 rtl/mult_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mult_arbiter_pkg
// Shared definitions for the shared-multiplier arbiter:
//   state_t          - FSM state encoding (IDLE, ISSUE, GAP, RESP)
//   clog2()          - ceiling log2, never less than 1 so index ports are
//                      always at least one bit wide
//   default_timeout()- default multiplier watchdog limit for a given width
// No ports (package).
// ----------------------------------------------------------------------------
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // A multi-cycle multiplier of this width should finish well inside
    // four cycles per operand bit.
    function automatic int default_timeout(input int width);
        return 4 * width;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_grant.sv
// ----------------------------------------------------------------------------
// rr_grant
// Combinational round-robin selector. The search starts at last+1 and wraps
// modulo NREQ, so the most recently served requester has lowest priority.
// Ports:
//   req   in  NREQ         request vector
//   last  in  clog2(NREQ)  index of the most recent grant
//   grant out NREQ         one-hot grant (all zero when req is all zero)
//   idx   out clog2(NREQ)  index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module rr_grant
    import mult_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]        grant,
    output logic [clog2(NREQ)-1:0] idx
);

    localparam int IDW = clog2(NREQ);

    logic           found;
    logic [IDW-1:0] pos;

    // Walk the NREQ positions after 'last'; the first requester found wins.
    // k runs to NREQ so 'last' itself is considered at the very end.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = IDW'((int'(last) + k) % NREQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// ----------------------------------------------------------------------------
// mult_arbiter
// Shares one multi-cycle multiplier between NREQ requesters. One operation is
// outstanding at a time: grant (IDLE) -> hold start level (ISSUE) -> enforced
// low time on the start level (GAP) -> wait for result consumer (RESP).
//
// Handshakes:
//   Request side: requester i holds req_valid[i] with stable operands; a
//   transfer happens on the clock edge where req_valid[i] && req_ready[i].
//   req_ready is a one-hot, single-cycle pulse derived combinationally from
//   req_valid, so a requester that drops valid is never granted.
//   Response side: rsp_valid stays high with rsp_id/rsp_prod/rsp_err frozen
//   until the edge where rsp_valid && rsp_ready; it is low the cycle after.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/ready/sign per-requester request, accept pulse, signed flag
//   req_x, req_y         packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready      result handshake
//   rsp_id, rsp_prod     owner index and product of the result
//   rsp_err              watchdog expired; rsp_prod is 0 in that case
//   mul_dataIn, mul_sign multiplier start level and signed flag
//   mul_x, mul_y         multiplier operands (stable during ISSUE)
//   mul_dataOut, mul_prod multiplier done level and product
//   busy                 FSM not in IDLE
//   fsm_state            current FSM state (state_t encoding) for observation
// ----------------------------------------------------------------------------
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = default_timeout(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_sign,
    input  logic [NREQ*WIDTH-1:0]    req_x,
    input  logic [NREQ*WIDTH-1:0]    req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]       rsp_prod,
    output logic                     rsp_err,
    output logic                     mul_dataIn,
    output logic                     mul_sign,
    output logic [WIDTH-1:0]         mul_x,
    output logic [WIDTH-1:0]         mul_y,
    input  logic                     mul_dataOut,
    input  logic [2*WIDTH-1:0]       mul_prod,
    output logic                     busy,
    output logic [1:0]               fsm_state
);

    localparam int IDW = clog2(NREQ);
    localparam int WDW = clog2(TIMEOUT + 1);
    localparam int GCW = clog2(GAP + 1);

    state_t           state;
    state_t           state_nx;

    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   gnt_idx;
    logic [NREQ-1:0]  gnt_oh;
    logic [WDW-1:0]   wd;
    logic [GCW-1:0]   gap_cnt;

    logic             grant_fire;
    logic             op_done;
    logic             op_timeout;
    logic             gap_last;
    logic             rsp_fire;

    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic             sel_sign;

    rr_grant #(
        .NREQ (NREQ)
    ) u_rr_grant (
        .req   (req_valid),
        .last  (last_grant),
        .grant (gnt_oh),
        .idx   (gnt_idx)
    );

    assign rsp_fire   = rsp_valid & rsp_ready;
    assign gap_last   = (gap_cnt == GCW'(GAP - 1));
    assign mul_dataIn = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);
    assign fsm_state  = state;

    // Operand mux for the winning requester.
    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_sign = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_x    = req_x[i*WIDTH +: WIDTH];
                sel_y    = req_y[i*WIDTH +: WIDTH];
                sel_sign = req_sign[i];
            end
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nx   = state;
        grant_fire = 1'b0;
        op_done    = 1'b0;
        op_timeout = 1'b0;
        req_ready  = '0;
        case (state)
            S_IDLE: begin
                // A pending result blocks new grants.
                if ((|req_valid) && !rsp_valid) begin
                    grant_fire = 1'b1;
                    state_nx   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mul_dataOut) begin
                    op_done  = 1'b1;
                    state_nx = (GAP == 0) ? S_RESP : S_GAP;
                end else if (wd == WDW'(TIMEOUT - 1)) begin
                    // The watchdog reaches TIMEOUT on this cycle.
                    op_timeout = 1'b1;
                    state_nx   = (GAP == 0) ? S_RESP : S_GAP;
                end
            end
            S_GAP: begin
                // Look at rsp_valid as it will be after this edge, so a
                // handshake on the last GAP cycle does not strand us in RESP.
                if (gap_last) begin
                    state_nx = (rsp_valid && !rsp_ready) ? S_RESP : S_IDLE;
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        // Keep the accept pulse low while reset is applied.
        if (grant_fire && !rst) begin
            req_ready = gnt_oh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant capture, counters and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_x      <= '0;
            mul_y      <= '0;
            mul_sign   <= 1'b0;
            owner      <= '0;
            last_grant <= IDW'(NREQ - 1);
            wd         <= '0;
            gap_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_prod   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (grant_fire) begin
                mul_x      <= sel_x;
                mul_y      <= sel_y;
                mul_sign   <= sel_sign;
                owner      <= gnt_idx;
                last_grant <= gnt_idx;
            end

            // Watchdog counts ISSUE cycles and is zero on ISSUE entry.
            if (state == S_ISSUE && !op_done && !op_timeout) begin
                wd <= wd + 1'b1;
            end else begin
                wd <= '0;
            end

            if (state == S_GAP && !gap_last) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if (op_done) begin
                rsp_valid <= 1'b1;
                rsp_id    <= owner;
                rsp_prod  <= mul_prod;
                rsp_err   <= 1'b0;
            end else if (op_timeout) begin
                rsp_valid <= 1'b1;
                rsp_id    <= owner;
                rsp_prod  <= '0;
                rsp_err   <= 1'b1;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
